// File: rtl/demux1hot8_stream.sv
// demux1hot8_stream: one-entry registered 1-to-8 stream demultiplexer.
// One valid/ready producer feeds eight valid/ready consumers. A one-hot
// select steers each beat. Beats with an illegal select are dropped,
// pulse err and bump a saturating counter.
`timescale 1ns/1ps

module demux1hot8_stream #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned ERRW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [7:0]       in_sel,
  output logic [7:0]       out_valid,
  input  logic [7:0]       out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             err,
  output logic [ERRW-1:0]  err_cnt
);

  localparam int unsigned LANES = 8;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_data;
  logic [LANES-1:0]   r_dst;
  logic               r_err;
  logic [ERRW-1:0]    r_err_cnt;

  logic               w_full;
  logic               w_drain;
  logic               w_accept;
  logic               w_sel_legal;
  logic               w_load;
  logic               w_drop;
  logic               w_cnt_sat;

  // Exactly one select bit set: non-zero and clearing the lowest set bit leaves zero.
  assign w_sel_legal = (in_sel != LANES'(0)) &&
                       ((in_sel & (in_sel - LANES'(1))) == LANES'(0));

  // Handshake terms; only the selected lane's ready can drain the buffer.
  assign w_full   = (r_state == S_FULL);
  assign w_drain  = w_full && (|(r_dst & out_ready));
  assign in_ready = !w_full || w_drain;
  assign w_accept = in_valid && in_ready;

  assign w_cnt_sat = (r_err_cnt == {ERRW{1'b1}});

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus load/drop strobes for the datapath.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_drop      = 1'b0;
    unique case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          if (w_sel_legal) begin
            w_state_nxt = S_FULL;
            w_load      = 1'b1;
          end else begin
            w_drop      = 1'b1;
          end
        end
      end
      S_FULL: begin
        if (w_drain) begin
          if (w_accept && w_sel_legal) begin
            w_state_nxt = S_FULL;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = S_EMPTY;
            w_drop      = w_accept;
          end
        end
      end
      default: begin
        w_state_nxt = S_EMPTY;
      end
    endcase
  end

  // Payload and destination register; destination clears when the buffer empties
  // so out_valid is a direct register output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_dst  <= '0;
    end else if (w_load) begin
      r_data <= in_data;
      r_dst  <= in_sel;
    end else if (w_state_nxt == S_EMPTY) begin
      r_dst  <= '0;
    end
  end

  // Drop reporting: one-cycle err pulse and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_err <= w_drop;
      if (w_drop && !w_cnt_sat) begin
        r_err_cnt <= r_err_cnt + ERRW'(1);
      end
    end
  end

  assign out_valid = r_dst;
  assign out_data  = r_data;
  assign err       = r_err;
  assign err_cnt   = r_err_cnt;

endmodule
